// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: shadow E/M/W tracking, stall, forwarding, stall count.
// Optional MDU interlock enabled by defining HAZARD_MDU_STALL_EN.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_a1,
  input  logic [4:0]  d_a2,
  input  logic [1:0]  d_tuse1,
  input  logic [1:0]  d_tuse2,
  input  logic [4:0]  d_a3,
  input  logic [1:0]  d_tnew,
  input  logic        d_mdureq,
  input  logic        mdu_start,
  input  logic        mdu_busy,
  output logic        stall,
  output logic [1:0]  fwd_d1,
  output logic [1:0]  fwd_d2,
  output logic [1:0]  fwd_e1,
  output logic [1:0]  fwd_e2,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_NEAR = 2'd1;
  localparam logic [1:0] FWD_FAR  = 2'd2;

  logic [4:0] e_a1, e_a2, e_a3, m_a3, w_a3;
  logic [1:0] e_tnew, m_tnew;

  logic       data_stall1, data_stall2, mdu_stall;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // An E match shadows any M match for the same operand, for both stall and forwarding.
  function automatic logic op_stall(input logic [4:0] a, input logic [1:0] tuse,
                                    input logic [4:0] ea3, input logic [1:0] etn,
                                    input logic [4:0] ma3, input logic [1:0] mtn);
    logic hit_e, hit_m;
    hit_e = (a != 5'd0) && (a == ea3);
    hit_m = (a != 5'd0) && (a == ma3);
    if (hit_e) return etn > tuse;
    return hit_m && (mtn > tuse);
  endfunction

  function automatic logic [1:0] op_fwd_d(input logic [4:0] a,
                                          input logic [4:0] ea3, input logic [1:0] etn,
                                          input logic [4:0] ma3, input logic [1:0] mtn);
    logic hit_e, hit_m;
    hit_e = (a != 5'd0) && (a == ea3);
    hit_m = (a != 5'd0) && (a == ma3);
    if (hit_e) return (etn == 2'd0) ? FWD_NEAR : FWD_NONE;
    if (hit_m && (mtn == 2'd0)) return FWD_FAR;
    return FWD_NONE;
  endfunction

  function automatic logic [1:0] op_fwd_e(input logic [4:0] a,
                                          input logic [4:0] ma3, input logic [1:0] mtn,
                                          input logic [4:0] wa3);
    if ((a != 5'd0) && (a == ma3) && (mtn == 2'd0)) return FWD_NEAR;
    if ((a != 5'd0) && (a == wa3)) return FWD_FAR;
    return FWD_NONE;
  endfunction

`ifdef HAZARD_MDU_STALL_EN
  assign mdu_stall = d_mdureq && (mdu_busy || mdu_start);
`else
  // MDU inputs are deliberately inert in this build; the MDU is interlocked elsewhere.
  assign mdu_stall = 1'b0 & d_mdureq & mdu_busy & mdu_start;
`endif

  always_comb begin
    data_stall1 = 1'b0;
    data_stall2 = 1'b0;
    fwd_d1      = FWD_NONE;
    fwd_d2      = FWD_NONE;
    fwd_e1      = FWD_NONE;
    fwd_e2      = FWD_NONE;
    data_stall1 = op_stall(d_a1, d_tuse1, e_a3, e_tnew, m_a3, m_tnew);
    data_stall2 = op_stall(d_a2, d_tuse2, e_a3, e_tnew, m_a3, m_tnew);
    fwd_d1      = op_fwd_d(d_a1, e_a3, e_tnew, m_a3, m_tnew);
    fwd_d2      = op_fwd_d(d_a2, e_a3, e_tnew, m_a3, m_tnew);
    fwd_e1      = op_fwd_e(e_a1, m_a3, m_tnew, w_a3);
    fwd_e2      = op_fwd_e(e_a2, m_a3, m_tnew, w_a3);
  end

  assign stall = data_stall1 | data_stall2 | mdu_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_a1   <= 5'd0;
      e_a2   <= 5'd0;
      e_a3   <= 5'd0;
      e_tnew <= 2'd0;
      m_a3   <= 5'd0;
      m_tnew <= 2'd0;
      w_a3   <= 5'd0;
    end else begin
      if (stall) begin
        e_a1   <= 5'd0;
        e_a2   <= 5'd0;
        e_a3   <= 5'd0;
        e_tnew <= 2'd0;
      end else begin
        e_a1   <= d_a1;
        e_a2   <= d_a2;
        e_a3   <= d_a3;
        e_tnew <= sat_dec(d_tnew);
      end
      m_a3   <= e_a3;
      m_tnew <= sat_dec(e_tnew);
      w_a3   <= m_a3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic against an instruction-history model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_a1, d_a2, d_a3;
  logic [1:0]  d_tuse1, d_tuse2, d_tnew;
  logic        d_mdureq, mdu_start, mdu_busy;
  logic        stall;
  logic [1:0]  fwd_d1, fwd_d2, fwd_e1, fwd_e2;
  logic [31:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_a1(d_a1), .d_a2(d_a2), .d_tuse1(d_tuse1), .d_tuse2(d_tuse2),
    .d_a3(d_a3), .d_tnew(d_tnew),
    .d_mdureq(d_mdureq), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
    .stall(stall), .fwd_d1(fwd_d1), .fwd_d2(fwd_d2),
    .fwd_e1(fwd_e1), .fwd_e2(fwd_e2), .stall_cnt(stall_cnt)
  );

  // Model: the last three instructions that left D (index 0 = in E, 1 = in M, 2 = in W),
  // each remembered with its D-stage Tnew; a bubble is an all-zero entry.
  typedef struct { int a1; int a2; int a3; int tnew; } instr_t;
  instr_t hist [3];
  longint m_cnt;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int remaining(input int idx);
    return (hist[idx].tnew > idx + 1) ? hist[idx].tnew - (idx + 1) : 0;
  endfunction

  function automatic bit m_op_stall(input int a, input int tuse);
    if (a == 0) return 0;
    if (a == hist[0].a3) return remaining(0) > tuse;
    if (a == hist[1].a3) return remaining(1) > tuse;
    return 0;
  endfunction

  function automatic int m_fwd_d(input int a);
    if (a == 0) return 0;
    if (a == hist[0].a3) return (remaining(0) == 0) ? 1 : 0;
    if (a == hist[1].a3 && remaining(1) == 0) return 2;
    return 0;
  endfunction

  function automatic int m_fwd_e(input int a);
    if (a == 0) return 0;
    if (a == hist[1].a3 && remaining(1) == 0) return 1;
    if (a == hist[2].a3) return 2;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = m_op_stall(d_a1, d_tuse1) || m_op_stall(d_a2, d_tuse2);
`ifdef HAZARD_MDU_STALL_EN
    s = s || (d_mdureq && (mdu_busy || mdu_start));
`endif
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
    m_cnt = 0;
  endtask

  task automatic drive(input int a1, input int a2, input int tu1, input int tu2,
                       input int a3, input int tn, input bit req, input bit st, input bit bz);
    @(negedge clk);
    d_a1 = 5'(a1); d_a2 = 5'(a2); d_tuse1 = 2'(tu1); d_tuse2 = 2'(tu2);
    d_a3 = 5'(a3); d_tnew = 2'(tn);
    d_mdureq = req; mdu_start = st; mdu_busy = bz;
    #1;
  endtask

  task automatic model_check();
    chk("stall", stall, m_stall());
    chk("fwd_d1", fwd_d1, m_fwd_d(d_a1));
    chk("fwd_d2", fwd_d2, m_fwd_d(d_a2));
    chk("fwd_e1", fwd_e1, m_fwd_e(hist[0].a1));
    chk("fwd_e2", fwd_e2, m_fwd_e(hist[0].a2));
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic adv();
    bit s;
    s = m_stall();
    @(posedge clk);
    if (s) m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (s) hist[0] = '{0, 0, 0, 0};
    else   hist[0] = '{int'(d_a1), int'(d_a2), int'(d_a3), int'(d_tnew)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    d_a1 = 0; d_a2 = 0; d_a3 = 0; d_tuse1 = 0; d_tuse2 = 0; d_tnew = 0;
    d_mdureq = 0; mdu_start = 0; mdu_busy = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd_e1", fwd_e1, 0);
    chk("rst_cnt", stall_cnt, 0);
    adv();

    // lw $8 then addu $9,$8,$8 (tuse 1): one stall while lw is in E
    drive(0, 0, 0, 0, 8, 3, 0, 0, 0); model_check(); adv();
    drive(8, 8, 1, 1, 9, 2, 0, 0, 0); model_check(); chk("lu_stall_e", stall, 1); adv();
    drive(8, 8, 1, 1, 9, 2, 0, 0, 0); model_check(); chk("lu_stall_m", stall, 0);
    chk("lu_fwd_d1", fwd_d1, 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); model_check();
    chk("lu_fwd_e1", fwd_e1, 2); chk("lu_fwd_e2", fwd_e2, 2); chk("lu_cnt", stall_cnt, 1); adv();

    // addu $8 then beq $8,$0 (tuse 0)
    do_reset();
    drive(0, 0, 0, 0, 8, 2, 0, 0, 0); model_check(); adv();
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0); model_check(); chk("beq_stall", stall, 1); adv();
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0); model_check();
    chk("beq_stall2", stall, 0); chk("beq_fwd_d1", fwd_d1, 2); adv();

    // jal then jr $31
    drive(0, 0, 0, 0, 31, 1, 0, 0, 0); model_check(); adv();
    drive(31, 0, 0, 0, 0, 0, 0, 0, 0); model_check();
    chk("jr_stall", stall, 0); chk("jr_fwd_d1", fwd_d1, 1); adv();

    // writers of $0 in flight, reader of $0 in D
    drive(0, 0, 0, 0, 0, 3, 0, 0, 0); model_check(); adv();
    drive(0, 0, 0, 0, 0, 3, 0, 0, 0); model_check(); adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); model_check();
    chk("r0_stall", stall, 0); chk("r0_fwd_d1", fwd_d1, 0); chk("r0_fwd_e1", fwd_e1, 0); adv();

    // mflo in D while MDU busy for five cycles
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0, 1); model_check();
`ifdef HAZARD_MDU_STALL_EN
      chk("mdu_stall", stall, 1);
`else
      chk("mdu_stall", stall, 0);
`endif
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); model_check(); chk("mdu_free", stall, 0); adv();

    // reset asserted during a load-use stall
    drive(0, 0, 0, 0, 8, 3, 0, 0, 0); model_check(); adv();
    drive(8, 0, 0, 0, 9, 2, 0, 0, 0); model_check(); chk("mid_stall", stall, 1); adv();
    drive(8, 0, 0, 0, 9, 2, 0, 0, 0);
    reset = 1'b1; model_reset(); #1;
    chk("arst_stall", stall, 0);
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_fwd_d1", fwd_d1, 0);
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic on a small register set to provoke frequent matches
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 4), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      model_check();
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); model_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
